// File: rtl/mem_port_arbiter.sv
// Fetch/data port arbiter onto one single-ported memory, one transaction in flight, data port priority.
// Define MEM_ARB_STARVE_GUARD_EN to build the fetch-port starvation guard (STARVE_LIMIT consecutive losses).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state, state_nxt;
  logic   arb_c;
  logic   i_win_c;
  logic   force_i_c;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be within 1..15");
  end

  assign arb_c   = (state == IDLE) && (i_req || d_req);
  assign i_win_c = i_req && (!d_req || force_i_c);

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] i_wait_cnt;

  assign force_i_c = (i_wait_cnt == CNT_W'(STARVE_LIMIT));

  // Counts consecutive arbitrations the fetch port lost to the data port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_wait_cnt <= '0;
    end else if (arb_c) begin
      if (i_win_c || !i_req) begin
        i_wait_cnt <= '0;
      end else begin
        i_wait_cnt <= i_wait_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign force_i_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant and response strobes are steered to the owner in the cycle memory handshakes
  always_comb begin
    state_nxt = state;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_c) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          i_gnt     = !owner;
          d_gnt     = owner;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          i_rvalid  = !owner;
          d_rvalid  = owner;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Winner's request is captured once at arbitration and held until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (arb_c) begin
      owner <= !i_win_c;
      if (i_win_c) begin
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        mem_wstrb <= '0;
      end else begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_wstrb <= d_wstrb;
      end
    end
  end

  assign mem_req = (state == ISSUE);
  assign busy    = (state != IDLE);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus, memory responder, grant/response monitor.
module tb_mem_port_arbiter;

  localparam logic [31:0] I_BASE = 32'h300;
  localparam logic [31:0] D_BASE = 32'h400;

  logic        clk;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        busy, owner;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic        chk;
  } rsp_t;

  logic        gq [$];
  rsp_t        rq [$];
  logic [31:0] mem [logic [31:0]];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          gnt_dly = 0;
  int          rv_dly  = 0;
  bit          rand_dly = 1'b0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ftab(input int k);
    case (k)
      0: return 32'h0000_0013;
      1: return 32'h0010_0093;
      2: return 32'h0020_8113;
      3: return 32'h0031_01B3;
      4: return 32'h0041_8233;
      5: return 32'h0052_02B3;
      6: return 32'h0062_8333;
      default: return 32'h0073_03B3;
    endcase
  endfunction

  function automatic logic [31:0] dtab(input int k);
    case (k)
      0: return 32'h1111_1111;
      1: return 32'h2222_2222;
      2: return 32'h3333_3333;
      3: return 32'h4444_4444;
      4: return 32'h5555_5555;
      5: return 32'h6666_6666;
      6: return 32'h7777_7777;
      default: return 32'h8888_8888;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_gnt(input logic port);
    gq.push_back(port);
  endtask

  task automatic exp_rsp(input logic port, input logic [31:0] data, input logic chk);
    rsp_t r;
    r.port = port;
    r.data = data;
    r.chk  = chk;
    rq.push_back(r);
  endtask

  // Memory responder: programmable grant and response delays, byte-strobed writes
  initial begin : mem_model
    logic [31:0] a, wd, cur;
    logic [3:0]  ws;
    logic        we;
    int          gd, rdl;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hBAD0_BAD0;
    mem[32'h100] = 32'hDEAD_BEEF;
    for (int k = 0; k < 8; k++) begin
      mem[I_BASE + 32'(4*k)] = ftab(k);
      mem[D_BASE + 32'(4*k)] = dtab(k);
    end
    forever begin
      @(posedge clk); #1;
      if (!rst && mem_req) begin
        gd  = rand_dly ? int'($urandom_range(0, 5)) : gnt_dly;
        rdl = rand_dly ? int'($urandom_range(0, 5)) : rv_dly;
        repeat (gd) begin @(posedge clk); #1; end
        a  = mem_addr;
        we = mem_we;
        wd = mem_wdata;
        ws = mem_wstrb;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        repeat (rdl) begin @(posedge clk); #1; end
        cur = mem.exists(a) ? mem[a] : 32'h0;
        if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
          end
          mem[a] = cur;
          mem_rdata = 32'hBAD0_BAD0;
        end else begin
          mem_rdata = cur;
        end
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0_BAD0;
      end
    end
  end

  // Monitor: every grant and response is matched against the expectation queues
  initial begin : monitor
    rsp_t r;
    logic g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (i_gnt || d_gnt) begin
          if (gq.size() == 0) begin
            check("gnt_unexpected", 64'({i_gnt, d_gnt}), 64'(0));
          end else begin
            g = gq.pop_front();
            check("gnt_port", 64'({i_gnt, d_gnt}), 64'({~g, g}));
          end
        end
        if (i_rvalid || d_rvalid) begin
          if (rq.size() == 0) begin
            check("rvalid_unexpected", 64'({i_rvalid, d_rvalid}), 64'(0));
          end else begin
            r = rq.pop_front();
            check("rvalid_port", 64'({i_rvalid, d_rvalid}), 64'({~r.port, r.port}));
            if (r.chk) check("rdata", 64'(r.port ? d_rdata : i_rdata), 64'(r.data));
          end
        end
        if (mem_req || i_rvalid || d_rvalid) check("busy_active", 64'(busy), 64'(1));
      end
    end
  end

  // Holds each request until granted; data stream re-requests with no gap
  task automatic run_stream(input int nd, input int ni, input logic we, input logic [31:0] dbase,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            output int dt, output int it);
    int dk = 0;
    int ik = 0;
    int t  = 0;
    dt = -1;
    it = -1;
    @(posedge clk); #1;
    while ((dk < nd || ik < ni) && t < 1500) begin
      d_req   = (dk < nd);
      d_we    = we;
      d_addr  = dbase + 32'(4*(dk % 8));
      d_wdata = wdata;
      d_wstrb = wstrb;
      i_req   = (ik < ni);
      i_addr  = I_BASE + 32'(4*(ik % 8));
      @(negedge clk);
      if (d_gnt) begin dk++; dt = t; end
      if (i_gnt) begin ik++; it = t; end
      @(posedge clk); #1;
      t++;
    end
    d_req = 1'b0;
    i_req = 1'b0;
    d_we  = 1'b0;
    if (t >= 1500) check("stream_timeout", 64'(dk + ik), 64'(nd + ni));
  endtask

  task automatic drain();
    int t = 0;
    while ((rq.size() != 0 || gq.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", 64'(rq.size() + gq.size()), 64'(0));
    @(negedge clk);
    check("idle_after", 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, 64'({mem_req, mem_we, busy, owner, i_gnt, d_gnt, i_rvalid, d_rvalid}), 64'(0));
    check({tag, "_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
    check({tag, "_wstrb"}, 64'(mem_wstrb), 64'(0));
  endtask

  initial begin : main
    int dt, it, nd, ipos;
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("rst_held");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("rst_released");

    // Single fetch: gnt at N+1, rvalid at N+2, back in IDLE at N+3
    exp_gnt(1'b0);
    exp_rsp(1'b0, 32'hDEAD_BEEF, 1'b1);
    @(posedge clk); #1;
    i_addr = 32'h100;
    i_req  = 1'b1;
    @(negedge clk);
    check("fetch_n", 64'({i_gnt, busy, mem_req}), 64'(0));
    @(negedge clk);
    check("fetch_n1_gnt", 64'({i_gnt, d_gnt, mem_req, mem_we}), 64'(4'b1010));
    check("fetch_n1_addr", 64'({mem_wstrb, mem_addr}), 64'({4'h0, 32'h100}));
    @(posedge clk); #1 i_req = 1'b0;
    @(negedge clk);
    check("fetch_n2_rvalid", 64'({i_rvalid, d_rvalid}), 64'(2'b10));
    check("fetch_n2_rdata", 64'(i_rdata), 64'(32'hDEAD_BEEF));
    @(negedge clk);
    check("fetch_n3_idle", 64'(busy), 64'(0));
    drain();

    // Store held through three cycles of mem_gnt low
    gnt_dly = 3;
    exp_gnt(1'b1);
    exp_rsp(1'b1, 32'h0, 1'b0);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("store_hold_req", 64'({mem_req, mem_gnt, d_gnt}), 64'(3'b100));
      check("store_hold_addr", 64'({mem_we, mem_wstrb, mem_addr}), 64'({1'b1, 4'hF, 32'h200}));
      check("store_hold_wdata", 64'(mem_wdata), 64'(32'h1234_5678));
    end
    @(negedge clk);
    check("store_gnt", 64'({d_gnt, i_gnt}), 64'(2'b10));
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
    drain();
    gnt_dly = 0;

    // Partial store then readback: bytes 0 and 2 replaced
    exp_gnt(1'b1);
    exp_rsp(1'b1, 32'h0, 1'b0);
    run_stream(1, 0, 1'b1, 32'h200, 32'hAABB_CCDD, 4'h5, dt, it);
    drain();
    exp_gnt(1'b1);
    exp_rsp(1'b1, 32'h12BB_56DD, 1'b1);
    run_stream(1, 0, 1'b0, 32'h200, 32'h0, 4'h0, dt, it);
    drain();

    // Simultaneous requests: data first, fetch at the following arbitration
    exp_gnt(1'b1);
    exp_gnt(1'b0);
    exp_rsp(1'b1, dtab(0), 1'b1);
    exp_rsp(1'b0, ftab(0), 1'b1);
    run_stream(1, 1, 1'b0, D_BASE, 32'h0, 4'h0, dt, it);
    check("simul_gap", 64'(it - dt), 64'(3));
    drain();

    // Continuous data requests against one fetch request
    do_reset();
`ifdef MEM_ARB_STARVE_GUARD_EN
    nd = 8; ipos = 4;
`else
    nd = 50; ipos = 50;
`endif
    for (int j = 0; j < nd; j++) begin
      if (j == ipos) begin
        exp_gnt(1'b0);
        exp_rsp(1'b0, ftab(0), 1'b1);
      end
      exp_gnt(1'b1);
      exp_rsp(1'b1, dtab(j % 8), 1'b1);
    end
    if (ipos == nd) begin
      exp_gnt(1'b0);
      exp_rsp(1'b0, ftab(0), 1'b1);
    end
    run_stream(nd, 1, 1'b0, D_BASE, 32'h0, 4'h0, dt, it);
    drain();

    // Back-to-back fetches with random memory delays
    rand_dly = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_gnt(1'b0);
      exp_rsp(1'b0, ftab(k), 1'b1);
    end
    run_stream(0, 8, 1'b0, D_BASE, 32'h0, 4'h0, dt, it);
    drain();
    rand_dly = 1'b0;

    // Reset while in RESP; the late memory response must be dropped
    rv_dly = 5;
    exp_gnt(1'b1);
    run_stream(1, 0, 1'b0, D_BASE, 32'h0, 4'h0, dt, it);
    check("mid_rst_before", 64'({owner, busy, mem_req}), 64'(3'b110));
    #3 rst = 1'b1;
    #1 check_outputs_zero("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_rst_idle", 64'({busy, d_rvalid, i_rvalid}), 64'(0));
    rv_dly = 0;

    exp_gnt(1'b0);
    exp_rsp(1'b0, ftab(0), 1'b1);
    run_stream(0, 1, 1'b0, D_BASE, 32'h0, 4'h0, dt, it);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
